batalha_naval_nucleo: RTL and testbench

- Parametrised sequential core of the battleship game; replaces the fixed 7x5, 3-life, switch-hardwired game logic with one configurable FSM.
- Owns the mode state machine, latched ship map, shot history, hit/miss judgement, life and hit counters, and win/loss detection.
- Sits between the switch/button front end (debounced one-cycle confirm pulse) and the LED-matrix/7-segment/RGB drivers.
- Exports a flattened display matrix plus counters for those drivers.

---
 rtl/batalha_naval_nucleo.sv | 204 ++++++++++++++++++++
 tb/tb_batalha_naval_nucleo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/batalha_naval_nucleo.sv
// Battleship game core: mode FSM, latched ship map, shot history, life/hit
// counters, win/loss detection and timed status LEDs for the display drivers.
module batalha_naval_nucleo #(
  parameter int LINHAS        = 7,
  parameter int COLUNAS       = 5,
  parameter int VIDAS         = 3,
  parameter int STATUS_CICLOS = 1000,
  localparam int LW = (LINHAS > 2) ? $clog2(LINHAS) : 1,
  localparam int CW = (COLUNAS > 2) ? $clog2(COLUNAS) : 1,
  localparam int N  = LINHAS * COLUNAS,
  localparam int VW = $clog2(VIDAS + 1),
  localparam int AW = $clog2(N + 1)
) (
  input  logic          clock_in,
  input  logic          rst_n,
  input  logic [1:0]    modo,
  input  logic          confirmar,
  input  logic [LW-1:0] coord_linha,
  input  logic [CW-1:0] coord_coluna,
  input  logic [N-1:0]  mapa_in,
  output logic [N-1:0]  matriz_out,
  output logic [2:0]    estado,
  output logic [VW-1:0] vida,
  output logic [AW-1:0] acertos,
  output logic          mapa_ok,
  output logic          LED_R,
  output logic          LED_G,
  output logic          LED_B
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam int SW = (STATUS_CICLOS > 1) ? $clog2(STATUS_CICLOS + 1) : 1;

  typedef enum logic [2:0] {
    DESLIGADO  = 3'd0,
    PREPARACAO = 3'd1,
    ATAQUE     = 3'd2,
    VITORIA    = 3'd3,
    DERROTA    = 3'd4
  } t_estado;

  function automatic logic [AW-1:0] f_popcount(input logic [N-1:0] v);
    logic [AW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + AW'(v[i]);
    return s;
  endfunction

  t_estado       r_estado, w_estado;
  logic [N-1:0]  r_mapa, w_mapa, r_tiros, w_tiros, r_matriz, w_matriz;
  logic          r_mapa_ok, w_mapa_ok;
  logic [AW-1:0] r_acertos, w_acertos;
  logic [VW-1:0] r_vida, w_vida;
  logic [2:0]    r_led, w_led;
  logic [SW-1:0] r_cnt, w_cnt;

  logic          w_valido, w_tirado, w_alvo, w_limpa;
  logic [IW-1:0] w_idx;
  logic [N-1:0]  w_sel;
  logic [AW-1:0] w_pop;
  logic [2:0]    w_evento;

  assign w_valido = (int'(coord_linha) < LINHAS) && (int'(coord_coluna) < COLUNAS);
  assign w_idx    = IW'(int'(coord_linha) * COLUNAS + int'(coord_coluna));
  assign w_sel    = {{(N-1){1'b0}}, 1'b1} << w_idx;
  assign w_tirado = |(r_tiros & w_sel);
  assign w_alvo   = |(r_mapa & w_sel);
  assign w_pop    = f_popcount(r_mapa);

  // Next-state, shot judgement, LED timer and display matrix
  always_comb begin
    w_estado  = r_estado;
    w_mapa    = r_mapa;
    w_mapa_ok = r_mapa_ok;
    w_tiros   = r_tiros;
    w_acertos = r_acertos;
    w_vida    = r_vida;
    w_evento  = 3'b000;
    w_limpa   = 1'b0;
    w_led     = r_led;
    w_cnt     = r_cnt;
    w_matriz  = r_matriz;

    case (r_estado)
      DESLIGADO: begin
        if (modo == 2'b01) w_estado = PREPARACAO;
        else               w_estado = DESLIGADO;
      end
      PREPARACAO: begin
        if (modo == 2'b10 && r_mapa_ok) begin
          w_estado  = ATAQUE;
          w_tiros   = '0;
          w_acertos = '0;
          w_vida    = VW'(VIDAS);
        end else if (confirmar) begin
          if (|mapa_in) begin
            w_mapa    = mapa_in;
            w_mapa_ok = 1'b1;
          end else begin
            w_evento = 3'b001;
          end
        end else begin
          w_estado = PREPARACAO;
        end
      end
      ATAQUE: begin
        if (!confirmar) begin
          w_estado = ATAQUE;
        end else if (!w_valido || w_tirado) begin
          w_evento = 3'b001;
        end else if (w_alvo) begin
          w_tiros   = r_tiros | w_sel;
          w_acertos = r_acertos + AW'(1);
          w_evento  = 3'b010;
          if (r_acertos + AW'(1) == w_pop) w_estado = VITORIA;
          else                             w_estado = ATAQUE;
        end else begin
          w_tiros  = r_tiros | w_sel;
          w_evento = 3'b100;
          if (r_vida != '0) w_vida = r_vida - VW'(1);
          else              w_vida = r_vida;
          if (r_vida <= VW'(1)) w_estado = DERROTA;
          else                  w_estado = ATAQUE;
        end
      end
      VITORIA: w_estado = VITORIA;
      DERROTA: w_estado = DERROTA;
      default: w_estado = DESLIGADO;
    endcase

    // Mode 00 overrides everything, including a coincident confirm
    if (modo == 2'b00) begin
      w_limpa   = 1'b1;
      w_estado  = DESLIGADO;
      w_mapa    = '0;
      w_mapa_ok = 1'b0;
      w_tiros   = '0;
      w_acertos = '0;
      w_vida    = VW'(VIDAS);
      w_evento  = 3'b000;
    end else begin
      w_limpa = 1'b0;
    end

    if (w_limpa || r_estado == DESLIGADO) begin
      w_led = 3'b000;
      w_cnt = '0;
    end else if (w_evento != 3'b000) begin
      w_led = w_evento;
      w_cnt = SW'(STATUS_CICLOS - 1);
    end else if (r_cnt != '0) begin
      w_cnt = r_cnt - SW'(1);
    end else begin
      w_led = 3'b000;
    end

    if (w_limpa) begin
      w_matriz = '0;
    end else begin
      case (r_estado)
        DESLIGADO:         w_matriz = '0;
        PREPARACAO:        w_matriz = mapa_in;
        ATAQUE:            w_matriz = r_tiros & r_mapa;
        VITORIA, DERROTA:  w_matriz = r_mapa;
        default:           w_matriz = '0;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= DESLIGADO;
      r_mapa    <= '0;
      r_mapa_ok <= 1'b0;
      r_tiros   <= '0;
      r_acertos <= '0;
      r_vida    <= VW'(VIDAS);
      r_led     <= 3'b000;
      r_cnt     <= '0;
      r_matriz  <= '0;
    end else begin
      r_estado  <= w_estado;
      r_mapa    <= w_mapa;
      r_mapa_ok <= w_mapa_ok;
      r_tiros   <= w_tiros;
      r_acertos <= w_acertos;
      r_vida    <= w_vida;
      r_led     <= w_led;
      r_cnt     <= w_cnt;
      r_matriz  <= w_matriz;
    end
  end

  assign matriz_out = r_matriz;
  assign estado     = r_estado;
  assign vida       = r_vida;
  assign acertos    = r_acertos;
  assign mapa_ok    = r_mapa_ok;
  assign LED_R      = r_led[2];
  assign LED_G      = r_led[1];
  assign LED_B      = r_led[0];

endmodule

// File: tb/tb_batalha_naval_nucleo.sv
// Directed bench for batalha_naval_nucleo: a 7x5/3-life board driven from a
// vector table plus hand sequences for LED timing and an 8x8/5-life board.
module tb_batalha_naval_nucleo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  modo = 2'b11;
  logic        conf = 1'b0;
  logic [2:0]  lin = 3'd0, col = 3'd0;
  logic [63:0] mapa = 64'd0;

  logic [34:0] mat0;
  logic [2:0]  est0, est1;
  logic [1:0]  vida0;
  logic [2:0]  vida1;
  logic [5:0]  ac0;
  logic [6:0]  ac1;
  logic [63:0] mat1;
  logic        ok0, ok1, r0, g0, b0, r1, g1, b1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  batalha_naval_nucleo #(.LINHAS(7), .COLUNAS(5), .VIDAS(3), .STATUS_CICLOS(1000)) dut0 (
    .clock_in(clk), .rst_n(rst_n), .modo(modo), .confirmar(conf),
    .coord_linha(lin), .coord_coluna(col), .mapa_in(mapa[34:0]),
    .matriz_out(mat0), .estado(est0), .vida(vida0), .acertos(ac0), .mapa_ok(ok0),
    .LED_R(r0), .LED_G(g0), .LED_B(b0));

  batalha_naval_nucleo #(.LINHAS(8), .COLUNAS(8), .VIDAS(5), .STATUS_CICLOS(4)) dut1 (
    .clock_in(clk), .rst_n(rst_n), .modo(modo), .confirmar(conf),
    .coord_linha(lin), .coord_coluna(col), .mapa_in(mapa),
    .matriz_out(mat1), .estado(est1), .vida(vida1), .acertos(ac1), .mapa_ok(ok1),
    .LED_R(r1), .LED_G(g1), .LED_B(b1));

  typedef struct {
    logic [1:0]  modo;
    logic        conf;
    logic [2:0]  lin;
    logic [2:0]  col;
    logic [34:0] mapa;
    logic [2:0]  est;
    logic [1:0]  vida;
    logic [5:0]  ac;
    logic        ok;
    logic [2:0]  led;
    logic [34:0] mat;
  } vec_t;

  vec_t v [26];

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // One pulse cycle, then one more edge with confirm low so matriz_out catches up
  task automatic step(input logic [1:0] m, input logic c, input logic [2:0] l,
                      input logic [2:0] k, input logic [63:0] mp);
    @(negedge clk);
    modo = m; conf = c; lin = l; col = k; mapa = mp;
    @(posedge clk); #1;
    conf = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    //          modo   cf    lin   col   mapa_in   est   vida  ac    ok    {R,G,B} matriz
    v[0]  = '{2'b01, 1'b0, 3'd0, 3'd0, 35'h81, 3'd1, 2'd3, 6'd0, 1'b0, 3'b000, 35'h81};
    v[1]  = '{2'b01, 1'b1, 3'd0, 3'd0, 35'h00, 3'd1, 2'd3, 6'd0, 1'b0, 3'b001, 35'h00};
    v[2]  = '{2'b10, 1'b0, 3'd0, 3'd0, 35'h81, 3'd1, 2'd3, 6'd0, 1'b0, 3'b001, 35'h81};
    v[3]  = '{2'b01, 1'b1, 3'd0, 3'd0, 35'h81, 3'd1, 2'd3, 6'd0, 1'b1, 3'b001, 35'h81};
    v[4]  = '{2'b10, 1'b0, 3'd0, 3'd0, 35'h81, 3'd2, 2'd3, 6'd0, 1'b1, 3'b001, 35'h00};
    v[5]  = '{2'b10, 1'b1, 3'd0, 3'd0, 35'h81, 3'd2, 2'd3, 6'd1, 1'b1, 3'b010, 35'h01};
    v[6]  = '{2'b10, 1'b1, 3'd0, 3'd0, 35'h81, 3'd2, 2'd3, 6'd1, 1'b1, 3'b001, 35'h01};
    v[7]  = '{2'b10, 1'b1, 3'd7, 3'd0, 35'h81, 3'd2, 2'd3, 6'd1, 1'b1, 3'b001, 35'h01};
    v[8]  = '{2'b10, 1'b1, 3'd3, 3'd0, 35'h81, 3'd2, 2'd2, 6'd1, 1'b1, 3'b100, 35'h01};
    v[9]  = '{2'b11, 1'b1, 3'd3, 3'd1, 35'h81, 3'd2, 2'd1, 6'd1, 1'b1, 3'b100, 35'h01};
    v[10] = '{2'b01, 1'b1, 3'd3, 3'd2, 35'h81, 3'd4, 2'd0, 6'd1, 1'b1, 3'b100, 35'h81};
    v[11] = '{2'b10, 1'b1, 3'd1, 3'd2, 35'h81, 3'd4, 2'd0, 6'd1, 1'b1, 3'b100, 35'h81};
    v[12] = '{2'b00, 1'b0, 3'd0, 3'd0, 35'h81, 3'd0, 2'd3, 6'd0, 1'b0, 3'b000, 35'h00};
    v[13] = '{2'b01, 1'b0, 3'd0, 3'd0, 35'h81, 3'd1, 2'd3, 6'd0, 1'b0, 3'b000, 35'h81};
    v[14] = '{2'b01, 1'b1, 3'd0, 3'd0, 35'h81, 3'd1, 2'd3, 6'd0, 1'b1, 3'b000, 35'h81};
    v[15] = '{2'b10, 1'b0, 3'd0, 3'd0, 35'h81, 3'd2, 2'd3, 6'd0, 1'b1, 3'b000, 35'h00};
    v[16] = '{2'b10, 1'b1, 3'd0, 3'd0, 35'h81, 3'd2, 2'd3, 6'd1, 1'b1, 3'b010, 35'h01};
    v[17] = '{2'b10, 1'b1, 3'd1, 3'd2, 35'h81, 3'd3, 2'd3, 6'd2, 1'b1, 3'b010, 35'h81};
    v[18] = '{2'b10, 1'b1, 3'd3, 3'd3, 35'h81, 3'd3, 2'd3, 6'd2, 1'b1, 3'b010, 35'h81};
    v[19] = '{2'b01, 1'b0, 3'd0, 3'd0, 35'h81, 3'd3, 2'd3, 6'd2, 1'b1, 3'b010, 35'h81};
    v[20] = '{2'b00, 1'b1, 3'd4, 3'd4, 35'h81, 3'd0, 2'd3, 6'd0, 1'b0, 3'b000, 35'h00};
    v[21] = '{2'b01, 1'b0, 3'd0, 3'd0, 35'h81, 3'd1, 2'd3, 6'd0, 1'b0, 3'b000, 35'h81};
    v[22] = '{2'b01, 1'b1, 3'd0, 3'd0, 35'h81, 3'd1, 2'd3, 6'd0, 1'b1, 3'b000, 35'h81};
    v[23] = '{2'b10, 1'b0, 3'd0, 3'd0, 35'h81, 3'd2, 2'd3, 6'd0, 1'b1, 3'b000, 35'h00};
    v[24] = '{2'b10, 1'b1, 3'd4, 3'd4, 35'h81, 3'd2, 2'd2, 6'd0, 1'b1, 3'b100, 35'h00};
    v[25] = '{2'b00, 1'b1, 3'd0, 3'd0, 35'h81, 3'd0, 2'd3, 6'd0, 1'b0, 3'b000, 35'h00};

    // Reset image while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_estado0", -1, 64'(est0), 64'd0);
    chk("rst_vida0", -1, 64'(vida0), 64'd3);
    chk("rst_acertos0", -1, 64'(ac0), 64'd0);
    chk("rst_ok0", -1, 64'(ok0), 64'd0);
    chk("rst_leds0", -1, 64'({r0, g0, b0}), 64'd0);
    chk("rst_matriz0", -1, 64'(mat0), 64'd0);
    chk("rst_vida1", -1, 64'(vida1), 64'd5);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(v[i].modo, v[i].conf, v[i].lin, v[i].col, 64'(v[i].mapa));
      chk("estado", i, 64'(est0), 64'(v[i].est));
      chk("vida", i, 64'(vida0), 64'(v[i].vida));
      chk("acertos", i, 64'(ac0), 64'(v[i].ac));
      chk("mapa_ok", i, 64'(ok0), 64'(v[i].ok));
      chk("leds", i, 64'({r0, g0, b0}), 64'(v[i].led));
      chk("matriz", i, 64'(mat0), 64'(v[i].mat));
    end

    // Status LED stays lit exactly STATUS_CICLOS cycles after a hit
    step(2'b01, 1'b0, 3'd0, 3'd0, 64'h81);
    step(2'b01, 1'b1, 3'd0, 3'd0, 64'h81);
    step(2'b10, 1'b0, 3'd0, 3'd0, 64'h81);
    chk("led_pre_shot", 100, 64'({r0, g0, b0}), 64'd0);
    @(negedge clk);
    conf = 1'b1; lin = 3'd0; col = 3'd0;
    @(posedge clk); #1;
    conf = 1'b0;
    chk("led_g_on", 101, 64'({r0, g0, b0}), 64'b010);
    chk("led_acertos", 101, 64'(ac0), 64'd1);
    repeat (999) @(posedge clk);
    #1;
    chk("led_g_last", 102, 64'({r0, g0, b0}), 64'b010);
    @(posedge clk); #1;
    chk("led_g_off", 103, 64'({r0, g0, b0}), 64'd0);

    // 8x8 board, 5 lives: far corner index 63, 3-bit life counter
    step(2'b00, 1'b0, 3'd0, 3'd0, 64'd0);
    step(2'b01, 1'b0, 3'd0, 3'd0, 64'h8000_0000_0000_0000);
    step(2'b01, 1'b1, 3'd0, 3'd0, 64'h8000_0000_0000_0000);
    chk("b8_ok", 200, 64'(ok1), 64'd1);
    chk("b8_preview", 200, mat1, 64'h8000_0000_0000_0000);
    step(2'b10, 1'b0, 3'd0, 3'd0, 64'd0);
    chk("b8_estado", 201, 64'(est1), 64'd2);
    chk("b8_vida", 201, 64'(vida1), 64'd5);
    step(2'b10, 1'b1, 3'd0, 3'd0, 64'd0);
    chk("b8_miss_vida", 202, 64'(vida1), 64'd4);
    chk("b8_miss_led", 202, 64'({r1, g1, b1}), 64'b100);
    step(2'b00, 1'b0, 3'd0, 3'd0, 64'd0);
    chk("b8_abort_estado", 203, 64'(est1), 64'd0);
    chk("b8_abort_vida", 203, 64'(vida1), 64'd5);
    chk("b8_abort_ok", 203, 64'(ok1), 64'd0);
    chk("b8_abort_led", 203, 64'({r1, g1, b1}), 64'd0);
    step(2'b01, 1'b0, 3'd0, 3'd0, 64'h8000_0000_0000_0000);
    step(2'b01, 1'b1, 3'd0, 3'd0, 64'h8000_0000_0000_0000);
    step(2'b10, 1'b0, 3'd0, 3'd0, 64'd0);
    step(2'b10, 1'b1, 3'd7, 3'd7, 64'd0);
    chk("b8_win_estado", 204, 64'(est1), 64'd3);
    chk("b8_win_acertos", 204, 64'(ac1), 64'd1);
    chk("b8_win_matriz", 204, mat1, 64'h8000_0000_0000_0000);
    chk("b8_win_led", 204, 64'({r1, g1, b1}), 64'b010);
    repeat (3) @(posedge clk);
    #1;
    chk("b8_led_off", 205, 64'({r1, g1, b1}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
